// File: rtl/spi_slave_rx_if.sv
// SPI slave receiver bus: SPI pins, mode selects, reply load path and
// received-byte outputs. The "master" modport is the side that drives the
// SPI lines and the reply byte; "slave" is the receiver itself.
interface spi_slave_rx_if;
    logic       polarity;
    logic       phase;
    logic       spi_clk;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_load;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;

    modport master (
        output polarity, phase, spi_clk, cs, mosi, tx_data, tx_load,
        input  miso, rx_data, rx_valid, busy
    );

    modport slave (
        input  polarity, phase, spi_clk, cs, mosi, tx_data, tx_load,
        output miso, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampling SPI slave in the clk domain. Synchronizes
// spi_clk/cs/mosi, rebuilds MSB-first bytes in any of the four SPI modes and
// pulses rx_valid once per byte, while shifting a reply byte out on miso.
// Optional feature macro: SPI_SLAVE_FRAME_ERR_EN adds a frame_err pulse when
// cs rises in the middle of a byte.
module spi_slave_rx #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic          clk,
    input  logic          reset,
    spi_slave_rx_if.slave bus
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic          frame_err
`endif
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   cs_prev;

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;
    logic leading_edge;
    logic trailing_edge;
    logic sample_edge;
    logic launch_edge;

    state_t     state;
    logic       busy_r;
    logic       pol_l;
    logic       pha_l;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] rx_data_r;
    logic       rx_valid_r;
    logic [7:0] tx_shift;
    logic [7:0] tx_buf;
    logic       tx_pending;
    logic       skip_launch;
    logic [7:0] reload_byte;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic       frame_err_r;
`endif

    // Clock and data synchronizers; these carry no control state so they
    // are left unreset and simply flush within SYNC_STAGES cycles.
    always_ff @(posedge clk) begin
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_clk};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
        sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end

    // cs synchronizer resets low so that a cs still held low after reset is
    // not mistaken for a fresh falling edge; a new frame needs cs high first.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync <= '0;
            cs_prev <= 1'b0;
        end else begin
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
            cs_prev <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = ~cs_s & cs_prev;

    // Edge classes use the mode latched at the start of the frame.
    assign leading_edge  = pol_l ? sclk_fall : sclk_rise;
    assign trailing_edge = pol_l ? sclk_rise : sclk_fall;
    assign sample_edge   = pha_l ? trailing_edge : leading_edge;
    assign launch_edge   = pha_l ? leading_edge  : trailing_edge;

    // A tx_load coinciding with a reload goes straight into the shifter.
    assign reload_byte = bus.tx_load ? bus.tx_data :
                         (tx_pending ? tx_buf : IDLE_BYTE);

    // Frame FSM with receive shifter, reply shifter and reply buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy_r      <= 1'b0;
            pol_l       <= 1'b0;
            pha_l       <= 1'b0;
            bit_cnt     <= 3'd0;
            rx_shift    <= 7'd0;
            rx_data_r   <= 8'd0;
            rx_valid_r  <= 1'b0;
            tx_shift    <= IDLE_BYTE;
            tx_buf      <= 8'd0;
            tx_pending  <= 1'b0;
            skip_launch <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_r <= 1'b0;
`endif
        end else begin
            rx_valid_r <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_r <= 1'b0;
`endif
            if (bus.tx_load) begin
                tx_buf     <= bus.tx_data;
                tx_pending <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state      <= ACTIVE;
                        busy_r     <= 1'b1;
                        pol_l      <= bus.polarity;
                        pha_l      <= bus.phase;
                        bit_cnt    <= 3'd0;
                        tx_shift   <= reload_byte;
                        tx_pending <= 1'b0;
                        // With phase=1 the first launch edge only presents
                        // the already-loaded MSB.
                        skip_launch <= bus.phase;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state   <= IDLE;
                        busy_r  <= 1'b0;
                        bit_cnt <= 3'd0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                        frame_err_r <= (bit_cnt != 3'd0);
`endif
                    end else if (sample_edge) begin
                        rx_shift <= {rx_shift[5:0], mosi_s};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_r  <= {rx_shift, mosi_s};
                            rx_valid_r <= 1'b1;
                            tx_shift   <= reload_byte;
                            tx_pending <= 1'b0;
                            // The next launch edge would otherwise shift away
                            // the freshly loaded MSB before it is sampled.
                            skip_launch <= 1'b1;
                        end
                    end else if (launch_edge) begin
                        if (skip_launch) begin
                            skip_launch <= 1'b0;
                        end else begin
                            tx_shift <= {tx_shift[6:0], 1'b1};
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.miso     = busy_r ? tx_shift[7] : 1'b1;
    assign bus.rx_data  = rx_data_r;
    assign bus.rx_valid = rx_valid_r;
    assign bus.busy     = busy_r;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    assign frame_err    = frame_err_r;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed testbench for spi_slave_rx: a behavioural SPI master drives
// frames in all four modes and records the miso reply bits it samples.
module tb_spi_slave_rx;

    localparam int HALF = 8;

    logic clk = 1'b0;
    logic reset;

    spi_slave_rx_if bus();

`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic frame_err;
`endif

    spi_slave_rx #(
        .SYNC_STAGES(2),
        .IDLE_BYTE  (8'hFF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] mtx [4];
    logic [7:0] mrx [4];
    logic [7:0] rxq [$];
    int         fe_cnt = 0;
    logic       snap_busy_mid;
    logic       snap_busy;
    logic       snap_miso;
    logic       snap_vld;
    logic [7:0] snap_data;

    // Record every rx_valid pulse and frame_err pulse.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) rxq.push_back(bus.rx_data);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        if (frame_err === 1'b1) fe_cnt++;
`endif
    end

    task automatic pulse_load(input logic [7:0] v);
        bus.tx_data = v;
        bus.tx_load = 1'b1;
        @(negedge clk);
        bus.tx_load = 1'b0;
    endtask

    // SPI master: sends mtx[] MSB-first, captures miso into mrx[].
    task automatic spi_frame(input logic p, input logic h, input int nbytes,
                             input int stop_bit, input int load_bit,
                             input logic [7:0] load_val, input int reset_bit);
        int total;
        int b;
        int k;
        total = (stop_bit >= 0) ? stop_bit : nbytes * 8;
        for (int j = 0; j < 4; j++) mrx[j] = 8'h00;
        bus.polarity = p;
        bus.phase    = h;
        bus.spi_clk  = p;
        repeat (HALF) @(negedge clk);
        bus.cs   = 1'b0;
        bus.mosi = mtx[0][7];
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < total; i++) begin
            b = i / 8;
            k = 7 - (i % 8);
            if (i == load_bit) pulse_load(load_val);
            if (i == reset_bit) begin
                reset = 1'b1;
                @(negedge clk);
                snap_busy = bus.busy;
                snap_miso = bus.miso;
                snap_vld  = bus.rx_valid;
                snap_data = bus.rx_data;
                reset = 1'b0;
            end
            if (i == 3) snap_busy_mid = bus.busy;
            bus.spi_clk = ~p;
            if (h) bus.mosi = mtx[b][k];
            else   mrx[b][k] = bus.miso;
            repeat (HALF) @(negedge clk);
            bus.spi_clk = p;
            if (h) mrx[b][k] = bus.miso;
            else if (i + 1 < total) bus.mosi = mtx[(i+1)/8][7-((i+1)%8)];
            repeat (HALF) @(negedge clk);
        end
        bus.cs = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++; if (bus.miso !== 1'b1) begin fails++; $display("FAIL reset_miso: got %b want 1", bus.miso); end
        tests++; if (bus.rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); end
        tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_mode0();
        rxq.delete();
        pulse_load(8'h3C);
        mtx[0] = 8'hA5;
        spi_frame(1'b0, 1'b0, 1, -1, -1, 8'h00, -1);
        tests++; if (snap_busy_mid !== 1'b1) begin fails++; $display("FAIL mode0_busy_mid: got %b want 1", snap_busy_mid); end
        tests++; if (rxq.size() !== 1) begin fails++; $display("FAIL mode0_pulses: got %0d want 1", rxq.size()); end
        tests++; if (rxq.size() > 0 && rxq[0] !== 8'hA5) begin fails++; $display("FAIL mode0_byte: got %h want a5", rxq[0]); end
        tests++; if (bus.rx_data !== 8'hA5) begin fails++; $display("FAIL mode0_rx_data: got %h want a5", bus.rx_data); end
        tests++; if (mrx[0] !== 8'h3C) begin fails++; $display("FAIL mode0_reply: got %h want 3c", mrx[0]); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL mode0_busy_end: got %b want 0", bus.busy); end
        tests++; if (fe_cnt !== 0) begin fails++; $display("FAIL mode0_frame_err: got %0d want 0", fe_cnt); end
    endtask

    task automatic test_modes();
        logic [7:0] reply [3];
        reply[0] = 8'h96;
        reply[1] = 8'h6C;
        reply[2] = 8'h3A;
        for (int m = 1; m <= 3; m++) begin
            rxq.delete();
            pulse_load(reply[m-1]);
            mtx[0] = 8'h81;
            spi_frame(m[1], m[0], 1, -1, -1, 8'h00, -1);
            tests++; if (rxq.size() !== 1) begin fails++; $display("FAIL mode%0d_pulses: got %0d want 1", m, rxq.size()); end
            tests++; if (bus.rx_data !== 8'h81) begin fails++; $display("FAIL mode%0d_rx_data: got %h want 81", m, bus.rx_data); end
            tests++; if (mrx[0] !== reply[m-1]) begin fails++; $display("FAIL mode%0d_reply: got %h want %h", m, mrx[0], reply[m-1]); end
        end
    endtask

    task automatic test_back_to_back();
        rxq.delete();
        mtx[0] = 8'h11;
        mtx[1] = 8'h22;
        mtx[2] = 8'h33;
        spi_frame(1'b0, 1'b0, 3, -1, -1, 8'h00, -1);
        tests++; if (rxq.size() !== 3) begin fails++; $display("FAIL b2b_pulses: got %0d want 3", rxq.size()); end
        if (rxq.size() == 3) begin
            tests++; if (rxq[0] !== 8'h11) begin fails++; $display("FAIL b2b_byte0: got %h want 11", rxq[0]); end
            tests++; if (rxq[1] !== 8'h22) begin fails++; $display("FAIL b2b_byte1: got %h want 22", rxq[1]); end
            tests++; if (rxq[2] !== 8'h33) begin fails++; $display("FAIL b2b_byte2: got %h want 33", rxq[2]); end
        end
        tests++; if (mrx[0] !== 8'hFF || mrx[1] !== 8'hFF || mrx[2] !== 8'hFF) begin
            fails++; $display("FAIL b2b_reply: got %h %h %h want ff ff ff", mrx[0], mrx[1], mrx[2]);
        end
    endtask

    task automatic test_abort();
        int fe0;
        fe0 = fe_cnt;
        rxq.delete();
        mtx[0] = 8'hC3;
        spi_frame(1'b0, 1'b0, 1, 5, -1, 8'h00, -1);
        tests++; if (rxq.size() !== 0) begin fails++; $display("FAIL abort_pulses: got %0d want 0", rxq.size()); end
        tests++; if (bus.rx_data !== 8'h33) begin fails++; $display("FAIL abort_rx_data: got %h want 33", bus.rx_data); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        tests++; if (fe_cnt - fe0 !== 1) begin fails++; $display("FAIL abort_frame_err: got %0d want 1", fe_cnt - fe0); end
`endif
    endtask

    task automatic test_reset_mid();
        rxq.delete();
        mtx[0] = 8'hF0;
        spi_frame(1'b0, 1'b0, 1, -1, -1, 8'h00, 4);
        tests++; if (snap_busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", snap_busy); end
        tests++; if (snap_miso !== 1'b1) begin fails++; $display("FAIL rstmid_miso: got %b want 1", snap_miso); end
        tests++; if (snap_vld !== 1'b0) begin fails++; $display("FAIL rstmid_rx_valid: got %b want 0", snap_vld); end
        tests++; if (snap_data !== 8'h00) begin fails++; $display("FAIL rstmid_rx_data: got %h want 00", snap_data); end
        tests++; if (rxq.size() !== 0) begin fails++; $display("FAIL rstmid_pulses: got %0d want 0", rxq.size()); end
        tests++; if (bus.rx_data !== 8'h00) begin fails++; $display("FAIL rstmid_rx_data_after: got %h want 00", bus.rx_data); end
        mtx[0] = 8'h5A;
        spi_frame(1'b0, 1'b0, 1, -1, -1, 8'h00, -1);
        tests++; if (rxq.size() !== 1) begin fails++; $display("FAIL rstmid_next_pulses: got %0d want 1", rxq.size()); end
        tests++; if (bus.rx_data !== 8'h5A) begin fails++; $display("FAIL rstmid_next_data: got %h want 5a", bus.rx_data); end
        tests++; if (mrx[0] !== 8'hFF) begin fails++; $display("FAIL rstmid_next_reply: got %h want ff", mrx[0]); end
    endtask

    task automatic test_tx_load_mid();
        rxq.delete();
        mtx[0] = 8'h12;
        mtx[1] = 8'h34;
        spi_frame(1'b0, 1'b1, 2, -1, 3, 8'h77, -1);
        tests++; if (rxq.size() !== 2) begin fails++; $display("FAIL txmid_pulses: got %0d want 2", rxq.size()); end
        if (rxq.size() == 2) begin
            tests++; if (rxq[0] !== 8'h12 || rxq[1] !== 8'h34) begin
                fails++; $display("FAIL txmid_bytes: got %h %h want 12 34", rxq[0], rxq[1]);
            end
        end
        tests++; if (mrx[0] !== 8'hFF) begin fails++; $display("FAIL txmid_reply0: got %h want ff", mrx[0]); end
        tests++; if (mrx[1] !== 8'h77) begin fails++; $display("FAIL txmid_reply1: got %h want 77", mrx[1]); end
    endtask

    initial begin
        bus.polarity = 1'b0;
        bus.phase    = 1'b0;
        bus.spi_clk  = 1'b0;
        bus.cs       = 1'b1;
        bus.mosi     = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_load  = 1'b0;
        reset        = 1'b1;
        test_reset();
        test_mode0();
        test_modes();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_tx_load_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
